// File: rtl/traffic_junction_ctrl_if.sv
// Bundle of junction controller mode inputs and light/walk/digit outputs.
// master drives the mode inputs; slave (the controller) drives the lights.
interface traffic_junction_if;
  logic       ena;
  logic       night_mode;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       ped_walk;
  logic       ped_pending;
  logic [6:0] seg;

  modport master (
    output ena, night_mode, ped_req,
    input  main_light, side_light, ped_walk, ped_pending, seg
  );

  modport slave (
    input  ena, night_mode, ped_req,
    output main_light, side_light, ped_walk, ped_pending, seg
  );
endinterface

// File: rtl/traffic_junction_ctrl.sv
// Two-road junction lights with pedestrian phase and night blink, stepped by a 1-tick/s prescaler.
// Outputs decode registered state with zero latency; no backpressure, ena=0 freezes all state.
module traffic_junction_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter int T_GREEN       = 9,
  parameter int T_GREEN_BLINK = 4,
  parameter int T_YELLOW      = 3,
  parameter int T_RED_YEL     = 2,
  parameter int T_ALL_RED     = 2,
  parameter int T_PED         = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  traffic_junction_if.slave  io
);

  typedef enum logic [3:0] {
    AR2   = 4'd0,
    M_RY  = 4'd1,
    M_GRN = 4'd2,
    M_BLK = 4'd3,
    M_YEL = 4'd4,
    AR1   = 4'd5,
    S_RY  = 4'd6,
    S_GRN = 4'd7,
    S_BLK = 4'd8,
    S_YEL = 4'd9,
    PED   = 4'd10,
    NIGHT = 4'd11
  } state_t;

  localparam int             DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);

  state_t        state_q, state_d, state_nxt;
  logic [3:0]    pc_q, pc_d;
  logic [DW-1:0] div_q, div_d;
  logic          ped_pending_q, ped_pending_d;
  logic          tick, last, enter_ped;
  logic [3:0]    dur, rem;
  logic          show_digit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= AR2;
      pc_q          <= 4'd0;
      div_q         <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      div_q         <= div_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (io.ena) begin
      if (div_q == DIV_MAX) begin
        div_d = '0;
        tick  = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    dur = 4'd1;
    case (state_q)
      M_GRN, S_GRN: dur = 4'(T_GREEN);
      M_BLK, S_BLK: dur = 4'(T_GREEN_BLINK);
      M_YEL, S_YEL: dur = 4'(T_YELLOW);
      M_RY,  S_RY:  dur = 4'(T_RED_YEL);
      AR1,   AR2:   dur = 4'(T_ALL_RED);
      PED:          dur = 4'(T_PED);
      default:      dur = 4'd1;
    endcase
  end

  assign last = (pc_q == dur - 4'd1);

  // Night takes priority over a pending walk at the end of a clearance phase.
  always_comb begin
    state_nxt = AR2;
    case (state_q)
      M_RY:    state_nxt = M_GRN;
      M_GRN:   state_nxt = M_BLK;
      M_BLK:   state_nxt = M_YEL;
      M_YEL:   state_nxt = AR1;
      AR1:     state_nxt = io.night_mode ? NIGHT : S_RY;
      S_RY:    state_nxt = S_GRN;
      S_GRN:   state_nxt = S_BLK;
      S_BLK:   state_nxt = S_YEL;
      S_YEL:   state_nxt = AR2;
      AR2:     state_nxt = io.night_mode ? NIGHT : (ped_pending_q ? PED : M_RY);
      PED:     state_nxt = M_RY;
      default: state_nxt = AR2;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    enter_ped = 1'b0;
    case (state_q)
      NIGHT: begin
        if (tick) begin
          if (!io.night_mode) begin
            state_d = AR2;
            pc_d    = 4'd0;
          end else begin
            pc_d = pc_q + 4'd1;
          end
        end
      end
      AR2, M_RY, M_GRN, M_BLK, M_YEL, AR1, S_RY, S_GRN, S_BLK, S_YEL, PED: begin
        if (tick) begin
          if (last) begin
            state_d   = state_nxt;
            pc_d      = 4'd0;
            enter_ped = (state_nxt == PED);
          end else begin
            pc_d = pc_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = AR2;
        pc_d    = 4'd0;
      end
    endcase
  end

  // A fresh press in the same cycle as the PED entry keeps the request latched.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (enter_ped) ped_pending_d = 1'b0;
    if (io.ena && io.ped_req && state_q != NIGHT) ped_pending_d = 1'b1;
  end

  assign rem = dur - pc_q;

  always_comb begin
    io.main_light = 3'b001;
    io.side_light = 3'b001;
    io.ped_walk   = 1'b0;
    show_digit    = 1'b0;
    case (state_q)
      M_RY:  io.main_light = 3'b011;
      M_GRN: begin io.main_light = 3'b100; show_digit = 1'b1; end
      M_BLK: io.main_light = pc_q[0] ? 3'b000 : 3'b100;
      M_YEL: io.main_light = 3'b010;
      S_RY:  io.side_light = 3'b011;
      S_GRN: begin io.side_light = 3'b100; show_digit = 1'b1; end
      S_BLK: io.side_light = pc_q[0] ? 3'b000 : 3'b100;
      S_YEL: io.side_light = 3'b010;
      PED:   begin io.ped_walk = 1'b1; show_digit = 1'b1; end
      NIGHT: begin
        io.main_light = pc_q[0] ? 3'b000 : 3'b010;
        io.side_light = pc_q[0] ? 3'b000 : 3'b010;
      end
      default: ;
    endcase
  end

  always_comb begin
    io.seg = 7'b0000000;
    if (show_digit) begin
      case (rem)
        4'd0:    io.seg = 7'b0111111;
        4'd1:    io.seg = 7'b0000110;
        4'd2:    io.seg = 7'b1011011;
        4'd3:    io.seg = 7'b1001111;
        4'd4:    io.seg = 7'b1100110;
        4'd5:    io.seg = 7'b1101101;
        4'd6:    io.seg = 7'b1111101;
        4'd7:    io.seg = 7'b0000111;
        4'd8:    io.seg = 7'b1111111;
        4'd9:    io.seg = 7'b1101111;
        default: io.seg = 7'b1000000;
      endcase
    end
  end

  assign io.ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Directed bench for traffic_junction_ctrl: phase-by-phase light, digit and pending checks.
// Inputs change #1 after the rising edge; outputs are sampled there and on every falling edge.
module tb_traffic_junction_ctrl;

  localparam int DIV = 2;
  localparam logic [2:0] R   = 3'b001;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b100;
  localparam logic [2:0] RY  = 3'b011;
  localparam logic [2:0] OFF = 3'b000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_junction_if tj();

  traffic_junction_ctrl #(.CLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (tj)
  );

  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int ped_from = -1;
  int ped_to   = -1;
  int nt_from  = -1;
  int nt_to    = -1;
  bit safe_on  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [6:0] digit(input int v);
    case (v)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Advance one clock; scheduled ped/night windows are applied before the edge.
  task automatic step();
    tj.ped_req    = (cyc >= ped_from && cyc < ped_to);
    tj.night_mode = (cyc >= nt_from && cyc < nt_to);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode: 0 steady, 1 main blinks G, 2 side blinks G, 3 night blink, 4 steady with digit
  task automatic phase(input string tag, input logic [2:0] m, input logic [2:0] s,
                       input logic w, input int dur, input int pc0, input int npc,
                       input int mode, input logic pend0, input int pend_k);
    int         pc;
    logic [2:0] em, es;
    logic [6:0] eseg;
    logic       ep;
    for (int k = 0; k < npc * DIV; k++) begin
      pc   = pc0 + k / DIV;
      em   = m;
      es   = s;
      eseg = 7'd0;
      if (mode == 1 && pc % 2 == 1) em = OFF;
      if (mode == 2 && pc % 2 == 1) es = OFF;
      if (mode == 3) begin
        em = (pc % 2 == 0) ? Y : OFF;
        es = em;
      end
      if (mode == 4) eseg = digit(dur - pc);
      ep = (pend_k >= 0 && k >= pend_k) ? 1'b1 : pend0;
      chk($sformatf("%s.main[%0d]", tag, k), tj.main_light, em);
      chk($sformatf("%s.side[%0d]", tag, k), tj.side_light, es);
      chk($sformatf("%s.walk[%0d]", tag, k), tj.ped_walk, w);
      chk($sformatf("%s.seg[%0d]", tag, k), tj.seg, eseg);
      chk($sformatf("%s.pend[%0d]", tag, k), tj.ped_pending, ep);
      step();
    end
  endtask

  task automatic ph(input string tag, input logic [2:0] m, input logic [2:0] s,
                    input logic w, input int dur, input int mode, input logic pend);
    phase(tag, m, s, w, dur, 0, dur, mode, pend, -1);
  endtask

  task automatic main_half(input string t, input logic pend);
    ph({t, ".mgrn"}, G, R, 1'b0, 9, 4, pend);
    ph({t, ".mblk"}, G, R, 1'b0, 4, 1, pend);
    ph({t, ".myel"}, Y, R, 1'b0, 3, 0, pend);
    ph({t, ".ar1"},  R, R, 1'b0, 2, 0, pend);
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".main"}, tj.main_light, R);
    chk({t, ".side"}, tj.side_light, R);
    chk({t, ".walk"}, tj.ped_walk, 1'b0);
    chk({t, ".pend"}, tj.ped_pending, 1'b0);
    chk({t, ".seg"},  tj.seg, 7'd0);
  endtask

  // Red on at least one road whenever a green is lit; walk only under all-red.
  always @(negedge clk) begin
    if (safe_on) begin
      chk("safe.red", !(!tj.main_light[0] && !tj.side_light[0] &&
                        (tj.main_light[2] || tj.side_light[2])), 1'b1);
      chk("safe.walk", !tj.ped_walk || (tj.main_light == R && tj.side_light == R), 1'b1);
    end
  end

  initial begin
    int c;
    tj.ena        = 1'b1;
    tj.night_mode = 1'b0;
    tj.ped_req    = 1'b0;
    rst_n         = 1'b0;
    step();
    step();
    chk_reset("t1.rst");
    safe_on = 1'b1;
    rst_n   = 1'b1;

    // Test 1: plain cycle without requests skips PED
    ph("t1.ar2", R, R, 1'b0, 2, 0, 1'b0);
    ph("t1.mry", RY, R, 1'b0, 2, 0, 1'b0);
    main_half("t1", 1'b0);
    ph("t1.sry",  R, RY, 1'b0, 2, 0, 1'b0);
    ph("t1.sgrn", R, G,  1'b0, 9, 4, 1'b0);
    ph("t1.sblk", R, G,  1'b0, 4, 2, 1'b0);
    ph("t1.syel", R, Y,  1'b0, 3, 0, 1'b0);
    ph("t1.ar2b", R, R,  1'b0, 2, 0, 1'b0);
    ph("t1.mryb", RY, R, 1'b0, 2, 0, 1'b0);

    // Test 2: one-clock press during side green, served after AR2
    main_half("t2", 1'b0);
    ph("t2.sry", R, RY, 1'b0, 2, 0, 1'b0);
    c = cyc;
    ped_from = c + 5;
    ped_to   = c + 6;
    phase("t2.sgrn", R, G, 1'b0, 9, 0, 9, 4, 1'b0, 6);
    ph("t2.sblk", R, G,  1'b0, 4, 2, 1'b1);
    ph("t2.syel", R, Y,  1'b0, 3, 0, 1'b1);
    ph("t2.ar2",  R, R,  1'b0, 2, 0, 1'b1);
    ph("t2.ped",  R, R,  1'b1, 6, 4, 1'b0);
    ph("t2.mry",  RY, R, 1'b0, 2, 0, 1'b0);

    // Test 3: request held across the PED entry tick stays latched
    main_half("t3", 1'b0);
    ph("t3.sry",  R, RY, 1'b0, 2, 0, 1'b0);
    ph("t3.sgrn", R, G,  1'b0, 9, 4, 1'b0);
    ph("t3.sblk", R, G,  1'b0, 4, 2, 1'b0);
    c = cyc;
    ped_from = c + 2;
    ped_to   = c + 12;
    phase("t3.syel", R, Y, 1'b0, 3, 0, 3, 0, 1'b0, 3);
    ph("t3.ar2",  R, R,  1'b0, 2, 0, 1'b1);
    ph("t3.ped",  R, R,  1'b1, 6, 4, 1'b1);
    ph("t3.mry",  RY, R, 1'b0, 2, 0, 1'b1);
    main_half("t3b", 1'b1);
    ph("t3b.sry",  R, RY, 1'b0, 2, 0, 1'b1);
    ph("t3b.sgrn", R, G,  1'b0, 9, 4, 1'b1);
    ph("t3b.sblk", R, G,  1'b0, 4, 2, 1'b1);
    ph("t3b.syel", R, Y,  1'b0, 3, 0, 1'b1);
    ph("t3b.ar2",  R, R,  1'b0, 2, 0, 1'b1);
    ph("t3b.ped",  R, R,  1'b1, 6, 4, 1'b0);
    ph("t3b.mry",  RY, R, 1'b0, 2, 0, 1'b0);

    // Test 4: night requested in main green; press during night is ignored
    c = cyc;
    nt_from  = c;
    nt_to    = c + 45;
    ped_from = c + 38;
    ped_to   = c + 40;
    main_half("t4", 1'b0);
    phase("t4.night", OFF, OFF, 1'b0, 0, 0, 5, 3, 1'b0, -1);
    ph("t4.ar2", R, R,  1'b0, 2, 0, 1'b0);
    ph("t4.mry", RY, R, 1'b0, 2, 0, 1'b0);

    // Test 5: ena low for 10 clocks in the dark half of main blink
    ph("t5.mgrn", G, R, 1'b0, 9, 4, 1'b0);
    phase("t5.mblk0", G, R, 1'b0, 4, 0, 1, 1, 1'b0, -1);
    c = cyc;
    ped_from = c + 2;
    ped_to   = c + 5;
    tj.ena   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5.frz.main[%0d]", i), tj.main_light, OFF);
      chk($sformatf("t5.frz.side[%0d]", i), tj.side_light, R);
      chk($sformatf("t5.frz.seg[%0d]", i),  tj.seg, 7'd0);
      chk($sformatf("t5.frz.pend[%0d]", i), tj.ped_pending, 1'b0);
      step();
    end
    tj.ena = 1'b1;
    phase("t5.mblk1", G, R, 1'b0, 4, 1, 3, 1, 1'b0, -1);
    ph("t5.myel", Y, R,  1'b0, 3, 0, 1'b0);
    ph("t5.ar1",  R, R,  1'b0, 2, 0, 1'b0);
    ph("t5.sry",  R, RY, 1'b0, 2, 0, 1'b0);

    // Test 6: one-clock reset in side green with a request latched
    c = cyc;
    ped_from = c + 1;
    ped_to   = c + 2;
    phase("t6.sgrn", R, G, 1'b0, 9, 0, 3, 4, 1'b0, 2);
    rst_n = 1'b0;
    step();
    chk_reset("t6.rst");
    rst_n = 1'b1;
    ph("t6.ar2",  R, R,  1'b0, 2, 0, 1'b0);
    ph("t6.mry",  RY, R, 1'b0, 2, 0, 1'b0);
    ph("t6.mgrn", G, R,  1'b0, 9, 4, 1'b0);

    safe_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
